// File: rtl/tile_addr_sequencer.sv
// Lockstep image/kernel BRAM address sequencer with a read-latency tracking pipeline.
// Optional macro SEQ_STALL_CNT_EN adds a saturating stall_cycles counter output.
module tile_addr_sequencer #(
    parameter int N_BANKS    = 8,
    parameter int IMG_ADDR_W = 14,
    parameter int KER_ADDR_W = 2,
    parameter int IMG_FIRST  = 0,
    parameter int IMG_LAST   = 15,
    parameter int IMG_WRAP   = 1,
    parameter int KER_FIRST  = 0,
    parameter int KER_LAST   = 3,
    parameter int KER_WRAP   = 1,
    parameter int N_ROWS     = 4,
    parameter int BRAM_LAT   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  stall,
    input  logic [N_BANKS-1:0]    bank_mask,
    output logic [N_BANKS-1:0]    bram_en,
    output logic [IMG_ADDR_W-1:0] img_addr,
    output logic [KER_ADDR_W-1:0] ker_addr,
    output logic                  data_valid,
    output logic                  row_done,
    output logic                  compute_done,
    output logic                  busy
`ifdef SEQ_STALL_CNT_EN
    ,
    output logic [15:0]           stall_cycles
`endif
);

    localparam logic [IMG_ADDR_W-1:0] IMG_FIRST_C = IMG_FIRST[IMG_ADDR_W-1:0];
    localparam logic [IMG_ADDR_W-1:0] IMG_LAST_C  = IMG_LAST[IMG_ADDR_W-1:0];
    localparam logic [IMG_ADDR_W-1:0] IMG_WRAP_C  = IMG_WRAP[IMG_ADDR_W-1:0];
    localparam logic [IMG_ADDR_W-1:0] IMG_ONE_C   = 1;
    localparam logic [KER_ADDR_W-1:0] KER_FIRST_C = KER_FIRST[KER_ADDR_W-1:0];
    localparam logic [KER_ADDR_W-1:0] KER_LAST_C  = KER_LAST[KER_ADDR_W-1:0];
    localparam logic [KER_ADDR_W-1:0] KER_WRAP_C  = KER_WRAP[KER_ADDR_W-1:0];
    localparam logic [KER_ADDR_W-1:0] KER_ONE_C   = 1;
    localparam logic [15:0]           ROW_LAST_C  = 16'(N_ROWS - 1);

    generate
        if (N_BANKS < 1 || IMG_ADDR_W < 1 || IMG_ADDR_W > 30 || KER_ADDR_W < 1 || KER_ADDR_W > 30 ||
            N_ROWS < 1 || N_ROWS > 65535 || BRAM_LAT < 1 || BRAM_LAT > 4 ||
            IMG_FIRST < 0 || IMG_FIRST >= (1 << IMG_ADDR_W) || IMG_LAST < 0 || IMG_LAST >= (1 << IMG_ADDR_W) ||
            IMG_WRAP < 0 || IMG_WRAP >= (1 << IMG_ADDR_W) || KER_FIRST < 0 || KER_FIRST >= (1 << KER_ADDR_W) ||
            KER_LAST < 0 || KER_LAST >= (1 << KER_ADDR_W) || KER_WRAP < 0 || KER_WRAP >= (1 << KER_ADDR_W))
        begin : g_bad_param
            $error("tile_addr_sequencer: parameter out of range");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t               state_r;
    state_t               next_state_s;
    logic [N_BANKS-1:0]   mask_r;
    logic [15:0]          row_cnt_r;
    logic [BRAM_LAT-1:0]  pipe_v_r;
    logic [BRAM_LAT-1:0]  pipe_l_r;
    logic                 accept_s;
    logic                 issue_s;
    logic                 final_s;
    logic                 img_last_s;

    assign img_last_s = (img_addr == IMG_LAST_C);
    assign data_valid = pipe_v_r[BRAM_LAT-1];
    assign row_done   = pipe_v_r[BRAM_LAT-1] & pipe_l_r[BRAM_LAT-1];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state and read-issue decode; a start is only seen in IDLE.
    always_comb begin
        next_state_s = state_r;
        accept_s     = 1'b0;
        issue_s      = 1'b0;
        final_s      = 1'b0;
        compute_done = 1'b0;
        busy         = 1'b1;
        bram_en      = {N_BANKS{1'b0}};
        case (state_r)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    accept_s     = 1'b1;
                    next_state_s = RUN;
                end else begin
                    next_state_s = IDLE;
                end
            end
            RUN: begin
                if (!stall) begin
                    issue_s = 1'b1;
                    bram_en = mask_r;
                    if (img_last_s && (row_cnt_r == ROW_LAST_C)) begin
                        final_s      = 1'b1;
                        next_state_s = DRAIN;
                    end else begin
                        next_state_s = RUN;
                    end
                end else begin
                    next_state_s = RUN;
                end
            end
            DRAIN: begin
                if (pipe_v_r == {BRAM_LAT{1'b0}}) begin
                    compute_done = 1'b1;
                    next_state_s = IDLE;
                end else begin
                    next_state_s = DRAIN;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Address generators, row counter and job mask; the final read leaves addresses parked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_r    <= {N_BANKS{1'b0}};
            row_cnt_r <= 16'd0;
            img_addr  <= {IMG_ADDR_W{1'b0}};
            ker_addr  <= {KER_ADDR_W{1'b0}};
        end else if (accept_s) begin
            mask_r    <= bank_mask;
            row_cnt_r <= 16'd0;
            img_addr  <= IMG_FIRST_C;
            ker_addr  <= KER_FIRST_C;
        end else if (issue_s && !final_s) begin
            if (img_last_s) begin
                img_addr  <= IMG_WRAP_C;
                row_cnt_r <= row_cnt_r + 16'd1;
            end else begin
                img_addr  <= img_addr + IMG_ONE_C;
            end
            if (ker_addr == KER_LAST_C) begin
                ker_addr <= KER_WRAP_C;
            end else begin
                ker_addr <= ker_addr + KER_ONE_C;
            end
        end
    end

    // Read-latency pipeline carrying {valid, row-end} for every issued read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_v_r <= {BRAM_LAT{1'b0}};
            pipe_l_r <= {BRAM_LAT{1'b0}};
        end else begin
            pipe_v_r[0] <= issue_s;
            pipe_l_r[0] <= issue_s & img_last_s;
            for (int i = 1; i < BRAM_LAT; i++) begin
                pipe_v_r[i] <= pipe_v_r[i-1];
                pipe_l_r[i] <= pipe_l_r[i-1];
            end
        end
    end

`ifdef SEQ_STALL_CNT_EN
    // Saturating count of stalled RUN cycles, cleared by each accepted job.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= 16'd0;
        end else if (accept_s) begin
            stall_cycles <= 16'd0;
        end else if ((state_r == RUN) && stall && (stall_cycles != 16'hFFFF)) begin
            stall_cycles <= stall_cycles + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_tile_addr_sequencer.sv
// Directed self-checking bench for tile_addr_sequencer (default build and BRAM_LAT=3/N_ROWS=1 build).
module tb_tile_addr_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_a = 1'b0;
    logic        start_b = 1'b0;
    logic        stall = 1'b0;
    logic [7:0]  bank_mask = 8'h00;

    logic [7:0]  bram_en_a, bram_en_b;
    logic [13:0] img_addr_a, img_addr_b;
    logic [1:0]  ker_addr_a, ker_addr_b;
    logic        dv_a, dv_b, rd_a, rd_b, cd_a, cd_b, busy_a, busy_b;
`ifdef SEQ_STALL_CNT_EN
    logic [15:0] sc_a, sc_b;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tile_addr_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start_a), .stall(stall), .bank_mask(bank_mask),
        .bram_en(bram_en_a), .img_addr(img_addr_a), .ker_addr(ker_addr_a),
        .data_valid(dv_a), .row_done(rd_a), .compute_done(cd_a), .busy(busy_a)
`ifdef SEQ_STALL_CNT_EN
        , .stall_cycles(sc_a)
`endif
    );

    tile_addr_sequencer #(.BRAM_LAT(3), .N_ROWS(1)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start_b), .stall(stall), .bank_mask(bank_mask),
        .bram_en(bram_en_b), .img_addr(img_addr_b), .ker_addr(ker_addr_b),
        .data_valid(dv_b), .row_done(rd_b), .compute_done(cd_b), .busy(busy_b)
`ifdef SEQ_STALL_CNT_EN
        , .stall_cycles(sc_b)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Moves to the next negedge; caller sets inputs then waits #1 before sampling.
    task automatic next_cycle();
        @(negedge clk);
    endtask

    initial begin
        int exp_img, exp_ker, dv_cnt, rd_cnt, cd_cnt, cd_cyc, first_rd, first_en, first_dv, last_dv;
        bit seen;

        // Reset state
        next_cycle(); next_cycle(); #1;
        chk("rst_bram_en", bram_en_a, 8'h00);
        chk("rst_img", img_addr_a, 14'd0);
        chk("rst_ker", ker_addr_a, 2'd0);
        chk("rst_dv", dv_a, 1'b0);
        chk("rst_cd", cd_a, 1'b0);
        chk("rst_busy", busy_a, 1'b0);
        next_cycle(); rst_n = 1'b1;

        // Full default job, no stall
        next_cycle(); bank_mask = 8'hFF; start_a = 1'b1;
        exp_img = 0; exp_ker = 0; dv_cnt = 0; rd_cnt = 0; cd_cnt = 0; cd_cyc = -1; first_rd = -1;
        for (int c = 0; c < 70; c++) begin
            next_cycle(); start_a = 1'b0; #1;
            if (c < 61) begin
                chk("run_img", img_addr_a, 32'(exp_img));
                chk("run_ker", ker_addr_a, 32'(exp_ker));
                chk("run_en", bram_en_a, 8'hFF);
                exp_img = (exp_img == 15) ? 1 : exp_img + 1;
                exp_ker = (exp_ker == 3) ? 1 : exp_ker + 1;
            end
            if (c == 61) begin
                chk("drain_en", bram_en_a, 8'h00);
                chk("drain_busy", busy_a, 1'b1);
                chk("drain_img", img_addr_a, 14'd15);
            end
            if (dv_a) dv_cnt++;
            if (rd_a) begin
                rd_cnt++;
                if (first_rd < 0) first_rd = c;
            end
            if (cd_a) begin
                cd_cnt++;
                cd_cyc = c;
            end
            if (c == 63) chk("post_idle", busy_a, 1'b0);
        end
        chk("job_dv_cnt", 32'(dv_cnt), 32'd61);
        chk("job_rd_cnt", 32'(rd_cnt), 32'd4);
        chk("job_first_rd", 32'(first_rd), 32'd16);
        chk("job_cd_cnt", 32'(cd_cnt), 32'd1);
        chk("job_cd_cyc", 32'(cd_cyc), 32'd62);

        // Three-cycle stall at img_addr 5
        next_cycle(); start_a = 1'b1;
        for (int c = 0; c < 13; c++) begin
            next_cycle(); start_a = 1'b0;
            stall = (c >= 5 && c <= 7);
            #1;
            chk("stall_img", img_addr_a, (c <= 5) ? 32'(c) : ((c <= 8) ? 32'd5 : 32'(c - 3)));
            chk("stall_en", bram_en_a, stall ? 8'h00 : 8'hFF);
            chk("stall_dv", dv_a, (c >= 1 && !(c >= 6 && c <= 8)) ? 1'b1 : 1'b0);
        end
`ifdef SEQ_STALL_CNT_EN
        chk("stall_cnt", sc_a, 16'd3);
`endif
        seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            next_cycle(); #1;
            if (cd_a) seen = 1'b1;
        end
        chk("stall_job_done", seen, 1'b1);

        // Reset mid-job at row 2, img_addr 7
        next_cycle(); start_a = 1'b1;
        for (int c = 0; c < 38; c++) begin
            next_cycle(); start_a = 1'b0; #1;
        end
        chk("pre_rst_img", img_addr_a, 14'd7);
        rst_n = 1'b0; #1;
        chk("mid_rst_en", bram_en_a, 8'h00);
        chk("mid_rst_img", img_addr_a, 14'd0);
        chk("mid_rst_ker", ker_addr_a, 2'd0);
        chk("mid_rst_dv", dv_a, 1'b0);
        chk("mid_rst_rd", rd_a, 1'b0);
        chk("mid_rst_cd", cd_a, 1'b0);
        chk("mid_rst_busy", busy_a, 1'b0);
        next_cycle(); rst_n = 1'b1;
        cd_cnt = 0; seen = 1'b0;
        for (int c = 0; c < 100; c++) begin
            next_cycle(); #1;
            if (cd_a) cd_cnt++;
            if (busy_a || dv_a) seen = 1'b1;
        end
        chk("no_ghost_cd", 32'(cd_cnt), 32'd0);
        chk("no_ghost_activity", seen, 1'b0);

        // Start held high, partial mask
        next_cycle(); bank_mask = 8'h05; start_a = 1'b1;
        cd_cnt = 0;
        for (int c = 0; c < 65; c++) begin
            next_cycle(); #1;
            if (c < 61) chk("hold_en", bram_en_a, 8'h05);
            if (cd_a && c < 64) cd_cnt++;
            if (c == 63) chk("hold_idle", busy_a, 1'b0);
            if (c == 64) begin
                chk("hold_restart", busy_a, 1'b1);
                chk("hold_restart_img", img_addr_a, 14'd0);
            end
        end
        chk("hold_cd_cnt", 32'(cd_cnt), 32'd1);
        start_a = 1'b0;
        next_cycle(); rst_n = 1'b0;
        next_cycle(); rst_n = 1'b1;

        // BRAM_LAT=3, single row
        next_cycle(); bank_mask = 8'hFF; start_b = 1'b1;
        first_en = -1; first_dv = -1; last_dv = -1; cd_cyc = -1; rd_cnt = 0;
        for (int c = 0; c < 30; c++) begin
            next_cycle(); start_b = 1'b0; #1;
            if (bram_en_b != 8'h00 && first_en < 0) first_en = c;
            if (dv_b) begin
                if (first_dv < 0) first_dv = c;
                last_dv = c;
            end
            if (rd_b) rd_cnt++;
            if (cd_b && cd_cyc < 0) cd_cyc = c;
        end
        chk("lat3_first_en", 32'(first_en), 32'd0);
        chk("lat3_first_dv", 32'(first_dv), 32'd3);
        chk("lat3_last_dv", 32'(last_dv), 32'd18);
        chk("lat3_cd_cyc", 32'(cd_cyc), 32'd19);
        chk("lat3_rd_cnt", 32'(rd_cnt), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
